// File: rtl/cam_pkg.sv
// cam_pkg: shared types and constants for the cam_tx camera transmitter.
//   cam_state_t : frame-timing FSM states
//   rgb444_t    : 12-bit pixel {R[3:0],G[3:0],B[3:0]}
//   CAM_PAD     : upper nibble of the first byte of each pixel
//   CAM_BARS    : 8-entry colour-bar table, index 0 = leftmost band
//   cam_max     : integer max, used for counter sizing
package cam_pkg;

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP} cam_state_t;

  typedef logic [11:0] rgb444_t;

  localparam logic [3:0] CAM_PAD = 4'hF;

  // Packed array: the last element of the concatenation is index 0.
  localparam logic [7:0][11:0] CAM_BARS = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F, 12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  function automatic int cam_max(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: internal colour-bar pixel source for cam_tx.
//   i_clk, i_rstn : clock, async active-low reset
//   i_fetch       : a pixel is consumed this cycle; advance the column
//   i_clr         : last byte of a row; restart at column 0
//   o_pix         : pixel for the current column (combinational from col_q)
// The row is split into 8 equal bands: band = column*8/(ROW_BYTES/2).
module cam_pattern_gen
  import cam_pkg::*;
#(
  parameter int ROW_BYTES = 1280
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_fetch,
  input  logic        i_clr,
  output logic [11:0] o_pix
);

  localparam int PIXW = ROW_BYTES / 2;
  localparam int CLW  = $clog2(PIXW + 1);

  logic [CLW-1:0] col_q;
  logic [2:0]     band;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)      col_q <= '0;
    else if (i_clr)   col_q <= '0;
    else if (i_fetch) col_q <= col_q + CLW'(1);
  end

  assign band  = 3'((32'(col_q) * 32'd8) / 32'(PIXW));
  assign o_pix = CAM_BARS[band];

endmodule

// File: rtl/cam_tx.sv
// cam_tx: OV7670-style parallel camera transmitter (vsync/href/8-bit data).
// Each RGB444 pixel goes out as two bytes: {CAM_PAD, R} then {G, B}.
//   i_clk, i_rstn        : pixel clock, async active-low reset
//   i_en                 : frame enable, looked at only in IDLE / last VFP cycle
//   i_pix_data/_valid    : upstream pixel stream
//   o_pix_rd             : pixel accept strobe (consumed with i_pix_valid)
//   o_vsync/o_href/o_data: camera bus, all registered
//   o_underflow          : strobe while no valid pixel; 000 is sent instead
//   o_frame_done         : pulse on the last VFP cycle
//   o_busy               : high outside IDLE
// Build option: define CAM_TX_PATTERN_EN to replace the upstream stream with
// the internal colour-bar generator (o_pix_rd/o_underflow then stay 0).
module cam_tx
  import cam_pkg::*;
#(
  parameter int ROWS        = 480,
  parameter int ROW_BYTES   = 1280,
  parameter int VSYNC_CLKS  = 4704,
  parameter int VBP_CLKS    = 26656,
  parameter int HBLANK_CLKS = 288,
  parameter int VFP_CLKS    = 16
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_en,
  input  logic [11:0] i_pix_data,
  input  logic        i_pix_valid,
  output logic        o_pix_rd,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_data,
  output logic        o_underflow,
  output logic        o_frame_done,
  output logic        o_busy
);

  localparam int MAXP = cam_max(cam_max(cam_max(VSYNC_CLKS, VBP_CLKS),
                                        cam_max(ROW_BYTES, HBLANK_CLKS)), VFP_CLKS);
  localparam int CW   = $clog2(MAXP + 1);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0] VS_LAST  = CW'(VSYNC_CLKS - 1);
  localparam logic [CW-1:0] VBP_LAST = CW'(VBP_CLKS - 1);
  localparam logic [CW-1:0] RB_LAST  = CW'(ROW_BYTES - 1);
  localparam logic [CW-1:0] HB_LAST  = CW'(HBLANK_CLKS - 1);
  localparam logic [CW-1:0] VFP_LAST = CW'(VFP_CLKS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  cam_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic          rd_int;
  rgb444_t       pix_in;
  logic [7:0]    lo_q, data_q;
  logic          vsync_q, href_q, done_q, busy_q;

  // cnt_q is the cycle index within the current state; in ACTIVE it is the
  // index of the byte currently on o_data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        row_d = '0;
        if (i_en) state_d = VSYNC;
      end
      VSYNC:  if (cnt_q == VS_LAST)  begin state_d = VBP;    cnt_d = '0; end
      VBP:    if (cnt_q == VBP_LAST) begin state_d = ACTIVE; cnt_d = '0; row_d = '0; end
      ACTIVE: if (cnt_q == RB_LAST) begin
        cnt_d   = '0;
        state_d = (row_q == ROW_LAST) ? VFP : HBLANK;
      end
      HBLANK: if (cnt_q == HB_LAST) begin
        state_d = ACTIVE;
        cnt_d   = '0;
        row_d   = row_q + RW'(1);
      end
      VFP: if (cnt_q == VFP_LAST) begin
        cnt_d   = '0;
        row_d   = '0;
        state_d = i_en ? VSYNC : IDLE;
      end
      default: begin state_d = IDLE; cnt_d = '0; row_d = '0; end
    endcase
  end

  // Fetch in the cycle before every even byte: end of VBP/HBLANK (byte 0)
  // and after each odd byte except the last one of the row.
  assign rd_int = (state_q == VBP    && cnt_q == VBP_LAST) ||
                  (state_q == HBLANK && cnt_q == HB_LAST)  ||
                  (state_q == ACTIVE && cnt_q[0] && cnt_q != RB_LAST);

`ifdef CAM_TX_PATTERN_EN
  logic [11:0] pat_pix;
  logic        unused_pix;

  cam_pattern_gen #(.ROW_BYTES(ROW_BYTES)) u_pat (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_fetch (rd_int),
    .i_clr   (state_q == ACTIVE && cnt_q == RB_LAST),
    .o_pix   (pat_pix)
  );

  assign pix_in      = pat_pix;
  assign o_pix_rd    = 1'b0;
  assign o_underflow = 1'b0;
  assign unused_pix  = ^{i_pix_valid, i_pix_data};
`else
  // A missing pixel is sent as black; timing never stalls.
  assign pix_in      = i_pix_valid ? i_pix_data : '0;
  assign o_pix_rd    = rd_int;
  assign o_underflow = rd_int & ~i_pix_valid;
`endif

  // Outputs are registered from the next-state values so they line up with
  // the state they describe.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      lo_q    <= '0;
      data_q  <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      vsync_q <= (state_d == VSYNC);
      href_q  <= (state_d == ACTIVE);
      done_q  <= (state_d == VFP) && (cnt_d == VFP_LAST);
      busy_q  <= (state_d != IDLE);
      if (rd_int) begin
        data_q <= {CAM_PAD, pix_in[11:8]};
        lo_q   <= pix_in[7:0];
      end else if (state_d == ACTIVE) begin
        data_q <= lo_q;
      end else begin
        data_q <= '0;
      end
    end
  end

  assign o_vsync      = vsync_q;
  assign o_href       = href_q;
  assign o_data       = data_q;
  assign o_frame_done = done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_cam_tx.sv
// Self-checking bench for cam_tx. The reference model describes a frame as
// closed-form timing (offset within frame -> row/byte position) plus the list
// of pixels the bench handed over, and compares every cycle of the bus.
module tb_cam_tx;

`ifdef CAM_TX_PATTERN_EN
  localparam bit PAT = 1'b1;
  localparam int RB  = 16;
`else
  localparam bit PAT = 1'b0;
  localparam int RB  = 8;
`endif
  localparam int ROWS = 3, VS = 4, VBP = 6, HB = 5, VFP = 3;
  localparam int P    = RB / 2;
  localparam int LINE = RB + HB;
  localparam int L    = VS + VBP + ROWS * RB + (ROWS - 1) * HB + VFP;

  logic        clk = 1'b0, rstn = 1'b0, en = 1'b0, pv = 1'b0;
  logic [11:0] pd = '0;
  logic        pix_rd, vsync, href, uf, done, busy;
  logic [7:0]  data;

  cam_tx #(.ROWS(ROWS), .ROW_BYTES(RB), .VSYNC_CLKS(VS), .VBP_CLKS(VBP),
           .HBLANK_CLKS(HB), .VFP_CLKS(VFP)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_en         (en),
    .i_pix_data   (pd),
    .i_pix_valid  (pv),
    .o_pix_rd     (pix_rd),
    .o_vsync      (vsync),
    .o_href       (href),
    .o_data       (data),
    .o_underflow  (uf),
    .o_frame_done (done),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  logic [11:0] bars [8]      = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
  logic [11:0] fmt_pix [4]   = '{12'hA5C, 12'h123, 12'hFFF, 12'h000};
  logic [7:0]  fmt_bytes [8] = '{8'hFA, 8'h5C, 8'hF1, 8'h23, 8'hFF, 8'hFF, 8'hF0, 8'h00};

  // model state
  bit          act = 1'b0;
  int          n = 0, fstart = 0, fidx = 0, fdone = 0;
  int          rd_obs = 0, uf_obs = 0, uf_exp = 0, done_obs = 0;
  logic [11:0] fpix [ROWS*P];
  logic [7:0]  hq [$];

  function automatic bit m_href(int rel);
    int d = rel - VS - VBP;
    if (rel >= L || d < 0) return 1'b0;
    return (d / LINE < ROWS) && (d % LINE < RB);
  endfunction
  function automatic int m_pos(int rel); return (rel - VS - VBP) % LINE; endfunction
  function automatic int m_row(int rel); return (rel - VS - VBP) / LINE; endfunction
  function automatic bit m_rd(int rel);  return m_href(rel + 1) && (m_pos(rel + 1) % 2 == 0); endfunction

  task automatic clr_counts();
    rd_obs = 0; uf_obs = 0; uf_exp = 0; done_obs = 0;
    hq.delete();
  endtask

  // mode: 0 random data, 1 random valid drops, 2 fixed format pixels,
  //       3 drop 2nd pixel of row 1
  task automatic cycle(input bit en_v, input int mode);
    int          rel;
    bit          rd, eh;
    logic [11:0] e_pix;
    logic [7:0]  e_byte;
    logic [31:0] got, want;
    @(posedge clk); #1;
    rel = act ? n - fstart : -100;
    rd  = act && m_rd(rel);
    en  = en_v;
    pd  = 12'($urandom);
    pv  = 1'b1;
    case (mode)
      1: pv = ($urandom_range(0, 3) != 0);
      2: pd = fmt_pix[fidx % 4];
      3: pv = (fidx != P + 1);
      default: ;
    endcase
    if (rd && fidx < ROWS * P) begin
      fpix[fidx] = PAT ? bars[((fidx % P) * 8) / P] : (pv ? pd : 12'h000);
      if (!PAT && !pv) uf_exp++;
      fidx++;
    end
    @(negedge clk);
    eh     = act && m_href(rel);
    e_pix  = eh ? fpix[m_row(rel) * P + m_pos(rel) / 2] : 12'h000;
    e_byte = !eh ? 8'h00 : (m_pos(rel) % 2 == 0) ? {4'hF, e_pix[11:8]} : e_pix[7:0];
    want = {18'd0, act && rel < VS, eh, e_byte, rd && !PAT, rd && !PAT && !pv,
            act && rel == L - 1, act};
    got  = {18'd0, vsync, href, data, pix_rd, uf, done, busy};
    chk($sformatf("bus_cyc%0d", n), got, want);
    if (pix_rd) rd_obs++;
    if (uf)     uf_obs++;
    if (done)   done_obs++;
    if (href)   hq.push_back(data);
    if (act && rel == L - 1) begin
      chk("rd_cnt", rd_obs, PAT ? 0 : ROWS * P);
      chk("uf_cnt", uf_obs, uf_exp);
      chk("done_cnt", done_obs, 1);
      if (mode == 2 && !PAT)
        for (int i = 0; i < 8; i++)
          chk($sformatf("fmt_b%0d", i), (hq.size() > i) ? 32'(hq[i]) : 32'hDEAD, 32'(fmt_bytes[i]));
      fdone++;
      clr_counts();
      if (en_v) begin fstart = n + 1; fidx = 0; end
      else act = 1'b0;
    end else if (!act && en_v) begin
      act = 1'b1; fstart = n + 1; fidx = 0;
      clr_counts();
    end
    n++;
  endtask

  task automatic run_frames(input int k, input bit en_v, input int mode);
    int target = fdone + k;
    int b = 0;
    while (fdone < target && b < 4 * k * L) begin cycle(en_v, mode); b++; end
    chk("frame_timeout", 32'(fdone >= target), 1);
  endtask

  task automatic mid_reset();
    int b = 0;
    while (!(act && m_href(n - fstart)) && b < 4 * L) begin cycle(1'b1, 0); b++; end
    chk("href_wait", 32'(b < 4 * L), 1);
    @(posedge clk); #2;
    chk("pre_rst_href", 32'(href), 1);
    rstn = 1'b0; #1;
    chk("rst_async", 32'({vsync, href, data, pix_rd, uf, done, busy}), 0);
    en = 1'b0; act = 1'b0; fidx = 0;
    clr_counts();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    int b;
    rstn = 1'b0; en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'({vsync, href, data, pix_rd, uf, done, busy}), 0);
    en = 1'b0; rstn = 1'b1;
    repeat (3) cycle(1'b0, 0);
    run_frames(2, 1'b1, 0);   // golden timing, back-to-back frames
    run_frames(1, 1'b1, 2);   // byte format
    run_frames(1, 1'b1, 3);   // single underflow
    run_frames(1, 1'b1, 1);   // random underflows
    // drop enable inside row 2: frame completes, then idle
    b = 0;
    while (!(act && m_href(n - fstart) && m_row(n - fstart) == 2) && b < 4 * L) begin
      cycle(1'b1, 0); b++;
    end
    chk("row2_wait", 32'(b < 4 * L), 1);
    run_frames(1, 1'b0, 0);
    repeat (5) cycle(1'b0, 0);
    mid_reset();
    repeat (3) cycle(1'b0, 0);
    run_frames(1, 1'b1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
